// File: rtl/rgmii_tx_ddr_sched_if.sv
// Purpose : GMII-side byte stream plus per-edge ODDR d1/d2 data for one RGMII TX port.
// Latency : n/a (signal bundle only).
// Backpressure: none on the bus; the MAC is paced by the gmii_clk_en byte strobe.
//
// Signals:
//   speed        line rate (00 10M, 01 100M, 1x 1000M)
//   gmii_txd/tx_en/tx_er  byte and flags from the MAC
//   gmii_clk_en  byte strobe back to the MAC
//   txd_d1/d2, ctl_d1/d2, clk_d1/d2  rising/falling-half values for the ODDRs
// master = MAC/driver side, slave = scheduler side.
interface rgmii_tx_ddr_sched_if;
    logic [1:0] speed;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       gmii_clk_en;
    logic [3:0] txd_d1;
    logic [3:0] txd_d2;
    logic       ctl_d1;
    logic       ctl_d2;
    logic       clk_d1;
    logic       clk_d2;

    modport master (
        output speed, gmii_txd, gmii_tx_en, gmii_tx_er,
        input  gmii_clk_en, txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2
    );

    modport slave (
        input  speed, gmii_txd, gmii_tx_en, gmii_tx_er,
        output gmii_clk_en, txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2
    );
endinterface

// File: rtl/rgmii_tx_ddr_sched.sv
// Purpose : turn a GMII TX byte stream into d1/d2 pairs for RGMII output DDR flops (data, ctl, fwd clock).
// Latency : 1 cycle from byte capture to the first d1/d2 pair carrying it.
// Backpressure: MAC is paced by gmii_clk_en; a byte is taken on every cycle the strobe is high.
//
// Ports:
//   clk  125 MHz TX clock        rst  asynchronous active-high reset
//   bus  rgmii_tx_ddr_sched_if.slave (GMII inputs, byte strobe, ODDR d1/d2 outputs)
// At 1000M one byte per cycle (low nibble rising, high nibble falling). At 10/100M each
// nibble is held for one synthesised RGMII clock period of N clk cycles (phase A = low
// nibble, phase B = high nibble), so a byte spans 2N cycles.
module rgmii_tx_ddr_sched #(
    parameter int CNT_100M = 5,    // clk cycles per RGMII period at 100M, >= 2
    parameter int CNT_10M  = 50    // clk cycles per RGMII period at 10M, >= 2
) (
    input  logic                 clk,
    input  logic                 rst,
    rgmii_tx_ddr_sched_if.slave  bus
);

    localparam int CNT_MAX = (CNT_100M > CNT_10M) ? CNT_100M : CNT_10M;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] SPD_100M = 2'b01;
    localparam logic [1:0] SPD_1G   = 2'b10;

    localparam logic [CW-1:0] LAST_100M = CW'(CNT_100M - 1);
    localparam logic [CW-1:0] LAST_10M  = CW'(CNT_10M - 1);
    localparam logic [CW-1:0] HALF_100M = CW'(CNT_100M / 2);
    localparam logic [CW-1:0] HALF_10M  = CW'(CNT_10M / 2);
    localparam logic          ODD_100M  = (CNT_100M % 2) == 1;
    localparam logic          ODD_10M   = (CNT_10M % 2) == 1;

    typedef enum logic {PH_A, PH_B} phase_t;

    // Scheduler state
    logic [1:0]    speed_reg, nxt_speed;
    phase_t        phase, nxt_phase;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          first;
    logic [7:0]    txd_q, nxt_txd;
    logic          en_q, nxt_en;
    logic          er_q, nxt_er;

    // Registered ODDR inputs
    logic [3:0]    txd_d1_q, txd_d2_q;
    logic          ctl_d1_q, ctl_d2_q;
    logic          clk_d1_q, clk_d2_q;

    // Values the output registers load on this edge
    logic [3:0]    out_txd1, out_txd2;
    logic          out_ctl1, out_ctl2;
    logic          out_clk1, out_clk2;

    logic          boundary;
    logic [CW-1:0] last_cur;
    logic [CW-1:0] half_nxt;
    logic          odd_nxt;
    logic [3:0]    nib_nxt;
    logic          ctl_err;

    // Period length follows the speed latched for the byte in flight, never the live input.
    assign last_cur = (speed_reg == SPD_100M) ? LAST_100M : LAST_10M;

    // The flag forces a boundary on the first cycle out of reset, so the first byte is
    // captured immediately whatever the reset-default phase/counter would imply.
    assign boundary = first | speed_reg[1] | ((phase == PH_B) && (cnt == last_cur));

    assign bus.gmii_clk_en = boundary & ~rst;

    // Next-state: a boundary restarts the byte; otherwise count through A then B.
    always_comb begin
        nxt_speed = speed_reg;
        nxt_phase = phase;
        nxt_cnt   = cnt;
        nxt_txd   = txd_q;
        nxt_en    = en_q;
        nxt_er    = er_q;
        if (boundary) begin
            nxt_speed = bus.speed;
            nxt_txd   = bus.gmii_txd;
            nxt_en    = bus.gmii_tx_en;
            nxt_er    = bus.gmii_tx_er;
            nxt_phase = PH_A;
            nxt_cnt   = '0;
        end else if (cnt == last_cur) begin
            // Only reachable in phase A; end of phase B is a boundary.
            nxt_phase = PH_B;
            nxt_cnt   = '0;
        end else begin
            nxt_cnt   = cnt + CW'(1);
        end
    end

    // Output decode from the next state, so the registered outputs line up with the
    // cycle index the state will hold after this edge (k = 0 right after a boundary).
    always_comb begin
        half_nxt = (nxt_speed == SPD_100M) ? HALF_100M : HALF_10M;
        odd_nxt  = (nxt_speed == SPD_100M) ? ODD_100M : ODD_10M;
        nib_nxt  = (nxt_phase == PH_B) ? nxt_txd[7:4] : nxt_txd[3:0];
        ctl_err  = nxt_en ^ nxt_er;

        out_txd1 = nib_nxt;
        out_txd2 = nib_nxt;
        out_ctl1 = ctl_err;
        out_ctl2 = ctl_err;
        out_clk1 = 1'b0;
        out_clk2 = 1'b0;

        if (nxt_speed[1]) begin
            out_txd1 = nxt_txd[3:0];
            out_txd2 = nxt_txd[7:4];
            out_ctl1 = nxt_en;
            out_ctl2 = ctl_err;
            out_clk1 = 1'b1;
            out_clk2 = 1'b0;
        end else if (nxt_cnt < half_nxt) begin
            // High half of the synthesised RGMII clock: ctl carries tx_en.
            out_ctl1 = nxt_en;
            out_ctl2 = nxt_en;
            out_clk1 = 1'b1;
            out_clk2 = 1'b1;
        end else if ((nxt_cnt == half_nxt) && odd_nxt) begin
            // Odd N: the falling clock edge lands mid-cycle, so split this cycle.
            out_ctl1 = nxt_en;
            out_ctl2 = ctl_err;
            out_clk1 = 1'b1;
            out_clk2 = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_reg <= SPD_1G;
            phase     <= PH_B;
            cnt       <= '0;
            first     <= 1'b1;
            txd_q     <= '0;
            en_q      <= 1'b0;
            er_q      <= 1'b0;
            txd_d1_q  <= '0;
            txd_d2_q  <= '0;
            ctl_d1_q  <= 1'b0;
            ctl_d2_q  <= 1'b0;
            clk_d1_q  <= 1'b0;
            clk_d2_q  <= 1'b0;
        end else begin
            speed_reg <= nxt_speed;
            phase     <= nxt_phase;
            cnt       <= nxt_cnt;
            first     <= 1'b0;
            txd_q     <= nxt_txd;
            en_q      <= nxt_en;
            er_q      <= nxt_er;
            txd_d1_q  <= out_txd1;
            txd_d2_q  <= out_txd2;
            ctl_d1_q  <= out_ctl1;
            ctl_d2_q  <= out_ctl2;
            clk_d1_q  <= out_clk1;
            clk_d2_q  <= out_clk2;
        end
    end

    assign bus.txd_d1 = txd_d1_q;
    assign bus.txd_d2 = txd_d2_q;
    assign bus.ctl_d1 = ctl_d1_q;
    assign bus.ctl_d2 = ctl_d2_q;
    assign bus.clk_d1 = clk_d1_q;
    assign bus.clk_d2 = clk_d2_q;

endmodule

// File: tb/tb_rgmii_tx_ddr_sched.sv
module tb_rgmii_tx_ddr_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #4 clk = ~clk;

    rgmii_tx_ddr_sched_if bus();

    rgmii_tx_ddr_sched #(.CNT_100M(5), .CNT_10M(50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] speed;
        logic [7:0] txd;
        logic       en;
        logic       er;
        logic [3:0] d1;
        logic [3:0] d2;
        logic       c1;
        logic       c2;
    } vec_t;

    vec_t vecs [6];
    int   pat5 [5];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [7:0] b, input logic e, input logic r);
        bus.speed      = s;
        bus.gmii_txd   = b;
        bus.gmii_tx_en = e;
        bus.gmii_tx_er = r;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_txd"}, {bus.txd_d1, bus.txd_d2}, 0);
        chk({nm, "_ctl"}, {bus.ctl_d1, bus.ctl_d2}, 0);
        chk({nm, "_clk"}, {bus.clk_d1, bus.clk_d2}, 0);
        chk({nm, "_stb"}, bus.gmii_clk_en, 0);
    endtask

    // Checks one slow-mode byte already captured on the previous edge, cycle by cycle,
    // up to index last_k. Optionally changes the speed input at cycle chg_k.
    task automatic slow_byte(input int n, input logic [7:0] b, input logic e, input logic r,
                             input int last_k, input int chg_k, input logic [1:0] chg_spd);
        int kk;
        int ck;
        logic [3:0] nib;
        for (int k = 0; k <= last_k; k++) begin
            kk  = k % n;
            nib = (k < n) ? b[3:0] : b[7:4];
            if (n == 5) ck = pat5[kk];
            else        ck = (kk < n / 2) ? 3 : 0;
            chk("slow_txd1", bus.txd_d1, nib);
            chk("slow_txd2", bus.txd_d2, nib);
            chk("slow_clk", {bus.clk_d1, bus.clk_d2}, ck);
            if (ck == 3)      chk("slow_ctl", {bus.ctl_d1, bus.ctl_d2}, {e, e});
            else if (ck == 2) chk("slow_ctl", {bus.ctl_d1, bus.ctl_d2}, {e, e ^ r});
            else              chk("slow_ctl", {bus.ctl_d1, bus.ctl_d2}, {e ^ r, e ^ r});
            chk("slow_stb", bus.gmii_clk_en, (k == 2 * n - 1) ? 1 : 0);
            if (k == chg_k) bus.speed = chg_spd;
            if (k < last_k) step();
        end
    endtask

    initial begin
        // 1000M vectors: {speed, txd, en, er, d1, d2, ctl1, ctl2}
        vecs[0] = '{2'b10, 8'hA5, 1'b1, 1'b0, 4'h5, 4'hA, 1'b1, 1'b1};
        vecs[1] = '{2'b10, 8'h3C, 1'b1, 1'b0, 4'hC, 4'h3, 1'b1, 1'b1};
        vecs[2] = '{2'b10, 8'h00, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 8'hFF, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1};
        vecs[4] = '{2'b10, 8'h81, 1'b0, 1'b0, 4'h1, 4'h8, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 8'h42, 1'b1, 1'b0, 4'h2, 4'h4, 1'b1, 1'b1};
        // 100M forwarded clock per cycle {clk_d1,clk_d2}: (1,1),(1,1),(1,0),(0,0),(0,0)
        pat5 = '{3, 3, 2, 0, 0};

        drive(2'b10, 8'h00, 1'b0, 1'b0);
        #1 rst = 1'b1;
        step();
        step();
        chk_zero("reset");

        // Release: first cycle is a boundary regardless of reset defaults.
        rst = 1'b0;
        #1;
        chk("first_stb", bus.gmii_clk_en, 1);

        // 1000M table
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].speed, vecs[i].txd, vecs[i].en, vecs[i].er);
            step();
            chk("g_txd1", bus.txd_d1, vecs[i].d1);
            chk("g_txd2", bus.txd_d2, vecs[i].d2);
            chk("g_ctl", {bus.ctl_d1, bus.ctl_d2}, {vecs[i].c1, vecs[i].c2});
            chk("g_clk", {bus.clk_d1, bus.clk_d2}, 2);
            chk("g_stb", bus.gmii_clk_en, 1);
        end

        // 100M, en=1 er=1
        drive(2'b01, 8'h7E, 1'b1, 1'b1);
        step();
        slow_byte(5, 8'h7E, 1'b1, 1'b1, 9, -1, 2'b01);

        // 100M byte with speed moved to 1000M at cycle 3 of phase A
        drive(2'b01, 8'hC3, 1'b1, 1'b0);
        step();
        slow_byte(5, 8'hC3, 1'b1, 1'b0, 9, 3, 2'b10);
        drive(2'b10, 8'h5A, 1'b1, 1'b0);
        step();
        chk("chg_txd", {bus.txd_d1, bus.txd_d2}, 8'hA5);
        chk("chg_clk", {bus.clk_d1, bus.clk_d2}, 2);
        chk("chg_ctl", {bus.ctl_d1, bus.ctl_d2}, 3);
        chk("chg_stb", bus.gmii_clk_en, 1);

        // 10M, en=1 er=0
        drive(2'b00, 8'h12, 1'b1, 1'b0);
        step();
        slow_byte(50, 8'h12, 1'b1, 1'b0, 99, -1, 2'b00);

        // 100M idle: two back-to-back bytes, clock must keep running
        drive(2'b01, 8'h96, 1'b0, 1'b0);
        step();
        slow_byte(5, 8'h96, 1'b0, 1'b0, 9, -1, 2'b01);
        drive(2'b01, 8'h0F, 1'b0, 1'b0);
        step();
        slow_byte(5, 8'h0F, 1'b0, 1'b0, 9, -1, 2'b01);

        // 10M byte interrupted by reset at phase B, cnt = 20
        drive(2'b00, 8'h34, 1'b1, 1'b1);
        step();
        slow_byte(50, 8'h34, 1'b1, 1'b1, 70, -1, 2'b00);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        step();
        step();
        chk_zero("midrst_hold");
        rst = 1'b0;
        #1;
        chk("rel_stb", bus.gmii_clk_en, 1);
        drive(2'b01, 8'h5A, 1'b1, 1'b0);
        step();
        slow_byte(5, 8'h5A, 1'b1, 1'b0, 9, -1, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_ddr_sched.md
Name: rgmii_tx_ddr_sched

Overview:
- Transmit-side scheduler that converts a GMII byte stream into per-cycle d1/d2 pairs for the output DDR flops of an RGMII interface: 4 data lines, 1 ctl line and 1 forwarded clock.
- Sits between the MAC GMII TX interface and the ODDR instances. Runs on the 125 MHz TX clock.
- At 1000 Mb/s it sends one byte per cycle, split across both clock edges.
- At 100 and 10 Mb/s it paces the MAC with a clock-enable strobe and emits each nibble over one full RGMII clock period. The period is synthesised from the DDR half-cycles.

Parameters:
- CNT_100M, 5: clk cycles per RGMII clock period at 100 Mb/s (125/25 MHz). Must be >= 2.
- CNT_10M, 50: clk cycles per RGMII clock period at 10 Mb/s (125/2.5 MHz). Must be >= 2.

Ports:
- clk, input, 1: TX clock, 125 MHz.
- rst, input, 1: reset.
- speed, input, 2: line rate. 00 = 10M, 01 = 100M, 10 = 1000M, 11 = treated as 1000M.
- gmii_txd, input, 8: TX byte from the MAC.
- gmii_tx_en, input, 1: TX enable.
- gmii_tx_er, input, 1: TX error.
- gmii_clk_en, output, 1: byte strobe. Inputs are captured on every cycle where it is high.
- txd_d1, output, 4: data for the rising half of the next cycle.
- txd_d2, output, 4: data for the falling half of the next cycle.
- ctl_d1, output, 1: ctl for the rising half.
- ctl_d2, output, 1: ctl for the falling half.
- clk_d1, output, 1: forwarded-clock value for the rising half.
- clk_d2, output, 1: forwarded-clock value for the falling half.

Behaviour:
- Interface (already decided): one clock, clk. Reset is rst, asynchronous and active-high. All state is clocked on posedge clk.
- Reset values:
  - All d1/d2 outputs 0.
  - gmii_clk_en 0 while rst is high.
  - Internal: speed_reg = 1000M, phase = B, cnt = 0, boundary flag set.
- Byte boundary: a cycle is a boundary if any of the following holds:
  - the boundary flag is set (first cycle after reset release);
  - speed_reg = 1000M;
  - phase = B and cnt = N-1, where N = CNT_100M or CNT_10M per speed_reg.
- gmii_clk_en is a combinational decode: (boundary) and not rst.
- Actions on a boundary edge:
  - Capture gmii_txd, gmii_tx_en and gmii_tx_er.
  - Load speed_reg from speed. speed is ignored at all other times, so a mid-byte change takes effect only at the next boundary.
  - Clear the boundary flag.
  - Set cnt = 0 and phase = A.
- 1000M mode:
  - Registered outputs, latency 1 cycle from capture.
  - txd_d1 = txd[3:0], txd_d2 = txd[7:4].
  - ctl_d1 = en, ctl_d2 = en ^ er.
  - clk_d1 = 1, clk_d2 = 0.
  - gmii_clk_en is constantly 1.
- 10M/100M mode:
  - cnt runs 0..N-1. At wrap, phase A -> B; at the end of B, the next byte boundary occurs.
  - Phase A emits nibble txd[3:0]; phase B emits txd[7:4]. txd_d1 = txd_d2 = nibble for the whole period.
  - Forwarded clock per cycle index k, with H = floor(N/2):
    - k < H: (1,1).
    - k = H and N odd: (1,0).
    - otherwise: (0,0).
  - ctl per k:
    - k < H: (en, en).
    - k = H and N odd: (en, en^er).
    - otherwise: (en^er, en^er).
  - Outputs are registered. The cycle after a boundary carries k = 0 of phase A.
  - gmii_clk_en: one pulse per 2N cycles.
- Speed change at a boundary:
  - The new pattern starts at k = 0 of the next byte.
  - No truncated clock period is emitted; the preceding period always completes.
- First cycle after reset release:
  - Boundary, strobe = 1, capture occurs.
  - Outputs reflect the captured byte on the following cycle.
- Reset mid-byte: asynchronous clear of all state and outputs to reset values. No partial nibble completes after rst falls.
- Idle (en = 0): the pattern continues normally with ctl = 0. The forwarded clock never stops.
- Clock and data change on the same edge. The RGMII skew is supplied outside this block.

Test Plan:
1. 1000M, bytes 0xA5 then 0x3C, en = 1, er = 0 -> strobe constantly 1. One cycle after each capture: txd_d1/d2 = 5/A, then C/3; ctl = (1,1); clk = (1,0).
2. 100M, byte 0x7E, en = 1, er = 1 -> strobe once per 10 cycles.
   - Cycles 0-4: txd = E; clk (1,1),(1,1),(1,0),(0,0),(0,0); ctl (1,1),(1,1),(1,0),(0,0),(0,0).
   - Cycles 5-9: txd = 7, same clk and ctl pattern.
3. 10M, byte 0x12, en = 1, er = 0 -> strobe period 100 cycles. txd = 2 for 50 cycles, then 1 for 50 cycles. clk = (1,1) for 25 cycles, then (0,0) for 25 cycles. ctl = 1 throughout.
4. speed changes 100M -> 1000M at cycle 3 of phase A -> the 100M byte completes all 10 cycles. 1000M pattern starts the cycle after the next strobe; no clock period shorter than 5 cycles is seen.
5. rst asserted at 10M phase B, cnt = 20 -> all outputs 0 immediately. After release: strobe = 1 in the first cycle, new byte captured, normal pattern follows.
6. 100M idle, en = 0 -> txd follows the nibbles of gmii_txd; ctl = (0,0); clk keeps a 5-cycle period continuously.
